// File: rtl/axi_burst_splitter_pkg.sv
// Local types for the burst splitter control path.
package axi_burst_splitter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CALC  = 2'd1,
        ST_ISSUE = 2'd2
    } split_state_e;

endpackage

// File: rtl/axi_pkg.sv
// Shared AXI address-channel constants and types used by the request splitters.
package axi_pkg;

    typedef enum logic [1:0] {
        AXI_BURST_FIXED = 2'b00,
        AXI_BURST_INCR  = 2'b01,
        AXI_BURST_WRAP  = 2'b10
    } axi_burst_e;

    localparam int unsigned AXI_LEN_WIDTH     = 8;
    localparam int unsigned AXI_SIZE_WIDTH    = 3;
    localparam int unsigned AXI_LEN_MAX_VALUE = 256;
    localparam int unsigned AXI_LEN_MAX_BYTES = 4096;
    localparam int unsigned AXI_FIXED_LEN_MAX = 16;
    localparam logic [11:0] AXI_4K_MASK       = 12'hFFF;

    // Command payload for the common 32-bit address configuration.
    typedef struct packed {
        logic [31:0]                addr;
        logic [AXI_LEN_WIDTH-1:0]   len;
        logic [AXI_SIZE_WIDTH-1:0]  size;
        axi_burst_e                 burst;
    } axi_cmd_t;

endpackage

// File: rtl/axi_burst_splitter_if.sv
// Request and command channels of the burst splitter; master is the splitter side.
interface axi_burst_splitter_if #(
    parameter int unsigned AW  = 32,
    parameter int unsigned BCW = 32
);
    import axi_pkg::*;

    logic                      req_valid;
    logic                      req_ready;
    logic [AW-1:0]             req_addr;
    logic [BCW-1:0]            req_byte_cnt;
    logic                      req_fixed;

    logic                      cmd_valid;
    logic                      cmd_ready;
    logic [AW-1:0]             cmd_addr;
    logic [AXI_LEN_WIDTH-1:0]  cmd_len;
    logic [AXI_SIZE_WIDTH-1:0] cmd_size;
    axi_burst_e                cmd_burst;
    logic                      cmd_last;

    modport master (
        input  req_valid, req_addr, req_byte_cnt, req_fixed, cmd_ready,
        output req_ready, cmd_valid, cmd_addr, cmd_len, cmd_size, cmd_burst, cmd_last
    );

    modport slave (
        output req_valid, req_addr, req_byte_cnt, req_fixed, cmd_ready,
        input  req_ready, cmd_valid, cmd_addr, cmd_len, cmd_size, cmd_burst, cmd_last
    );

endinterface

// File: rtl/axi_chunk_calc.sv
// Combinational sizing of the next burst: limited by remaining bytes, max burst length and the 4KB page.
module axi_chunk_calc
    import axi_pkg::*;
#(
    parameter int unsigned DW  = 32,
    parameter int unsigned BCW = 32
) (
    input  logic [11:0]              page_off,
    input  logic [BCW-1:0]           remaining,
    input  logic                     fixed,
    output logic [BCW:0]             chunk_bytes,
    output logic [AXI_LEN_WIDTH-1:0] len,
    output logic                     last
);
    localparam int unsigned CW  = BCW + 1;
    localparam int unsigned BPB = DW / 8;
    localparam int unsigned SZ  = $clog2(BPB);
    localparam int unsigned INCR_MAX_BYTES =
        (AXI_LEN_MAX_VALUE * BPB < AXI_LEN_MAX_BYTES) ? AXI_LEN_MAX_VALUE * BPB : AXI_LEN_MAX_BYTES;
    localparam int unsigned FIXED_MAX_BYTES = AXI_FIXED_LEN_MAX * BPB;

    logic [CW-1:0] rem_w;
    logic [CW-1:0] to_4k;
    logic [CW-1:0] cap;
    logic [CW-1:0] chunk;

    // Bytes left before the next 4KB boundary; 4096 needs the 13th bit.
    assign rem_w = CW'(remaining);
    assign to_4k = CW'(13'h1000 - {1'b0, page_off & AXI_4K_MASK});

    always_comb begin
        cap   = CW'(FIXED_MAX_BYTES);
        chunk = rem_w;
        if (!fixed) begin
            cap = (to_4k < CW'(INCR_MAX_BYTES)) ? to_4k : CW'(INCR_MAX_BYTES);
        end
        if (cap < rem_w) begin
            chunk = cap;
        end
    end

    assign chunk_bytes = chunk;
    assign len         = AXI_LEN_WIDTH'((chunk >> SZ) - CW'(1));
    assign last        = (chunk == rem_w);

endmodule

// File: rtl/axi_burst_splitter.sv
// Splits a linear transfer request into legal AXI address-channel bursts.
module axi_burst_splitter
    import axi_pkg::*;
    import axi_burst_splitter_pkg::*;
#(
    parameter int unsigned AW  = 32,
    parameter int unsigned DW  = 32,
    parameter int unsigned BCW = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    axi_burst_splitter_if.master bus,
    output logic                 busy,
    output logic                 done,
    output logic                 err
);
    localparam int unsigned BPB = DW / 8;
    localparam int unsigned SZ  = $clog2(BPB);

    split_state_e             state;
    logic [AW-1:0]            addr_q;
    logic [BCW-1:0]           rem_q;
    logic                     fixed_q;
    logic                     ready_q;
    logic [BCW:0]             chunk_q;
    logic [BCW:0]             chunk_w;
    logic [AXI_LEN_WIDTH-1:0] len_w;
    logic                     last_w;
    logic                     misaligned;

    axi_chunk_calc #(
        .DW  (DW),
        .BCW (BCW)
    ) u_chunk_calc (
        .page_off    (addr_q[11:0]),
        .remaining   (rem_q),
        .fixed       (fixed_q),
        .chunk_bytes (chunk_w),
        .len         (len_w),
        .last        (last_w)
    );

    assign misaligned    = (bus.req_addr[SZ-1:0] != '0) || (bus.req_byte_cnt[SZ-1:0] != '0);
    assign bus.cmd_size  = AXI_SIZE_WIDTH'(SZ);
    // Ready is held low for as long as reset is asserted, then comes up immediately in IDLE.
    assign bus.req_ready = ready_q && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_IDLE;
            ready_q       <= 1'b1;
            addr_q        <= '0;
            rem_q         <= '0;
            fixed_q       <= 1'b0;
            chunk_q       <= '0;
            bus.cmd_valid <= 1'b0;
            bus.cmd_addr  <= '0;
            bus.cmd_len   <= '0;
            bus.cmd_last  <= 1'b0;
            bus.cmd_burst <= AXI_BURST_INCR;
            busy          <= 1'b0;
            done          <= 1'b0;
            err           <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    ready_q <= 1'b1;
                    if (bus.req_valid && ready_q) begin
                        addr_q  <= bus.req_addr;
                        rem_q   <= bus.req_byte_cnt;
                        fixed_q <= bus.req_fixed;
                        // Rejected and empty requests complete without issuing anything.
                        if (misaligned) begin
                            done <= 1'b1;
                            err  <= 1'b1;
                        end else if (bus.req_byte_cnt == '0) begin
                            done <= 1'b1;
                        end else begin
                            state   <= ST_CALC;
                            ready_q <= 1'b0;
                            busy    <= 1'b1;
                        end
                    end
                end
                ST_CALC: begin
                    bus.cmd_addr  <= addr_q;
                    bus.cmd_len   <= len_w;
                    bus.cmd_last  <= last_w;
                    bus.cmd_burst <= fixed_q ? AXI_BURST_FIXED : AXI_BURST_INCR;
                    bus.cmd_valid <= 1'b1;
                    chunk_q       <= chunk_w;
                    state         <= ST_ISSUE;
                end
                ST_ISSUE: begin
                    if (bus.cmd_ready) begin
                        bus.cmd_valid <= 1'b0;
                        rem_q         <= rem_q - BCW'(chunk_q);
                        if (!fixed_q) begin
                            addr_q <= addr_q + AW'(chunk_q);
                        end
                        if (bus.cmd_last) begin
                            state   <= ST_IDLE;
                            ready_q <= 1'b1;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                        end else begin
                            state <= ST_CALC;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axi_burst_splitter.sv
// Directed bench for axi_burst_splitter (DW=32) with a per-cycle transaction-level reference model.
module tb_axi_burst_splitter;

    typedef struct packed {
        logic [31:0] addr;
        logic [7:0]  len;
        logic [1:0]  burst;
        logic        last;
    } cmd_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic busy, done, err;

    int n_vec  = 0;
    int n_fail = 0;
    int cyc    = 0;

    cmd_t exp_q[$];
    cmd_t obs_q[$];
    int   hs_cyc[$];
    bit   exp_done = 1'b0;
    bit   exp_err  = 1'b0;
    int   gap      = 0;
    bit   first_pending = 1'b0;
    int   acc_cyc = 0, first_v_cyc = 0, done_cyc = 0;

    axi_burst_splitter_if #(.AW(32), .BCW(32)) bus ();

    axi_burst_splitter #(.AW(32), .DW(32), .BCW(32)) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus.master),
        .busy (busy),
        .done (done),
        .err  (err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: expand a request into the full list of commands from the sizing rules.
    task automatic model_req(input logic [31:0] a, input logic [31:0] c, input bit f);
        longint unsigned rem, ad, ch, lim;
        cmd_t e;
        rem = c;
        ad  = a;
        if ((a % 4) != 0 || (c % 4) != 0) begin
            exp_done = 1'b1;
            exp_err  = 1'b1;
        end else if (c == 0) begin
            exp_done = 1'b1;
        end else begin
            while (rem > 0) begin
                if (f) begin
                    ch = (rem < 64) ? rem : 64;
                end else begin
                    lim = 4096 - (ad % 4096);
                    if (lim > 1024) lim = 1024;
                    ch = (rem < lim) ? rem : lim;
                end
                e.addr  = 32'(ad);
                e.len   = 8'(ch / 4 - 1);
                e.burst = f ? 2'b00 : 2'b01;
                e.last  = (ch == rem);
                exp_q.push_back(e);
                rem = rem - ch;
                if (!f) ad = (ad + ch) % 64'h1_0000_0000;
            end
            gap = 1;
        end
    endtask

    // Compare DUT against the model every cycle, then advance the model to the next edge.
    always @(negedge clk) begin
        cmd_t e;
        cmd_t o;
        bit   exp_v;
        exp_v = (exp_q.size() != 0) && (gap == 0);
        check("req_ready", bus.req_ready, !rst && (exp_q.size() == 0));
        check("busy", busy, exp_q.size() != 0);
        check("done", done, exp_done);
        check("err", err, exp_err);
        check("cmd_valid", bus.cmd_valid, exp_v);
        check("cmd_size", bus.cmd_size, 3'd2);
        if (exp_v) begin
            e = exp_q[0];
            check("cmd_addr", bus.cmd_addr, e.addr);
            check("cmd_len", bus.cmd_len, e.len);
            check("cmd_burst", 2'(bus.cmd_burst), e.burst);
            check("cmd_last", bus.cmd_last, e.last);
        end
        if (done) done_cyc = cyc;
        if (exp_v && first_pending) begin
            first_v_cyc   = cyc;
            first_pending = 1'b0;
        end
        exp_done = 1'b0;
        exp_err  = 1'b0;
        if (gap > 0) gap--;
        if (rst) begin
            exp_q.delete();
            gap = 0;
            first_pending = 1'b0;
        end else begin
            if (exp_v && bus.cmd_ready) begin
                o.addr  = bus.cmd_addr;
                o.len   = bus.cmd_len;
                o.burst = 2'(bus.cmd_burst);
                o.last  = bus.cmd_last;
                obs_q.push_back(o);
                hs_cyc.push_back(cyc);
                e = exp_q.pop_front();
                if (exp_q.size() == 0) exp_done = 1'b1;
                else gap = 1;
            end
            if (bus.req_valid && bus.req_ready) begin
                acc_cyc       = cyc;
                first_pending = 1'b1;
                model_req(bus.req_addr, bus.req_byte_cnt, bus.req_fixed);
            end
        end
    end

    task automatic send_req(input logic [31:0] a, input logic [31:0] c, input bit f);
        int n = 0;
        obs_q.delete();
        hs_cyc.delete();
        @(posedge clk); #1;
        bus.req_addr     = a;
        bus.req_byte_cnt = c;
        bus.req_fixed    = f;
        bus.req_valid    = 1'b1;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.req_ready && n < 20);
        if (!bus.req_ready) check("req_accept_timeout", 1'b0, 1'b1);
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
    endtask

    task automatic wait_done(input int max);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done && n < max);
        if (!done) check("done_timeout", 1'b0, 1'b1);
        @(posedge clk); #2;
    endtask

    task automatic wait_valid(input int max);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.cmd_valid && n < max);
        if (!bus.cmd_valid) check("cmd_valid_timeout", 1'b0, 1'b1);
    endtask

    task automatic check_obs(input int idx, input logic [31:0] a, input logic [7:0] l,
                             input logic [1:0] b, input logic lst);
        if (idx >= obs_q.size()) begin
            check("obs_missing", 32'(obs_q.size()), 32'(idx + 1));
        end else begin
            check("obs_addr", obs_q[idx].addr, a);
            check("obs_len", obs_q[idx].len, l);
            check("obs_burst", obs_q[idx].burst, b);
            check("obs_last", obs_q[idx].last, lst);
        end
    endtask

    task automatic check_test1();
        check("t1_count", 32'(obs_q.size()), 32'd2);
        check_obs(0, 32'h0FF0, 8'd3, 2'b01, 1'b0);
        check_obs(1, 32'h1000, 8'd11, 2'b01, 1'b1);
        if (hs_cyc.size() == 2) check("t1_done_delay", 32'(done_cyc - hs_cyc[1]), 32'd1);
    endtask

    initial begin
        bus.req_valid    = 1'b0;
        bus.req_addr     = '0;
        bus.req_byte_cnt = '0;
        bus.req_fixed    = 1'b0;
        bus.cmd_ready    = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_cmd_valid", bus.cmd_valid, 1'b0);
        check("rst_cmd_addr", bus.cmd_addr, 32'h0);
        check("rst_cmd_len", bus.cmd_len, 8'h0);
        check("rst_cmd_last", bus.cmd_last, 1'b0);
        check("rst_cmd_burst", 2'(bus.cmd_burst), 2'b01);
        check("rst_req_ready", bus.req_ready, 1'b1);
        check("rst_busy", busy, 1'b0);

        // 4KB crossing
        bus.cmd_ready = 1'b1;
        send_req(32'h0FF0, 32'h40, 1'b0);
        wait_done(50);
        check_test1();

        // full 4KB page in four maximal bursts
        send_req(32'h0000, 32'h1000, 1'b0);
        wait_done(50);
        check("t2_count", 32'(obs_q.size()), 32'd4);
        check("t2_latency", 32'(first_v_cyc - acc_cyc), 32'd2);
        for (int i = 0; i < 4; i++) begin
            check_obs(i, 32'(i * 32'h400), 8'd255, 2'b01, i == 3);
        end
        if (hs_cyc.size() == 4) check("t2_spacing", 32'(hs_cyc[3] - hs_cyc[2]), 32'd2);

        // FIXED burst capped at 16 beats
        send_req(32'h2000, 32'h50, 1'b1);
        wait_done(50);
        check("t3_count", 32'(obs_q.size()), 32'd2);
        check_obs(0, 32'h2000, 8'd15, 2'b00, 1'b0);
        check_obs(1, 32'h2000, 8'd3, 2'b00, 1'b1);

        // zero byte count
        send_req(32'h3000, 32'h0, 1'b0);
        wait_done(10);
        check("t4_count", 32'(obs_q.size()), 32'd0);
        check("t4_done_delay", 32'(done_cyc - acc_cyc), 32'd1);

        // misaligned address, then misaligned count
        send_req(32'h0002, 32'h10, 1'b0);
        wait_done(10);
        check("t5_count", 32'(obs_q.size()), 32'd0);
        check("t5_done_delay", 32'(done_cyc - acc_cyc), 32'd1);
        send_req(32'h0100, 32'h12, 1'b0);
        wait_done(10);
        check("t5b_count", 32'(obs_q.size()), 32'd0);

        // backpressure on the first command
        bus.cmd_ready = 1'b0;
        send_req(32'h0FF0, 32'h40, 1'b0);
        wait_valid(10);
        repeat (5) begin
            @(negedge clk);
            check("bp_valid", bus.cmd_valid, 1'b1);
            check("bp_addr", bus.cmd_addr, 32'h0FF0);
            check("bp_len", bus.cmd_len, 8'd3);
            check("bp_last", bus.cmd_last, 1'b0);
        end
        @(posedge clk); #1;
        bus.cmd_ready = 1'b1;
        wait_done(50);
        check_test1();

        // reset while a command is stalled
        bus.cmd_ready = 1'b0;
        send_req(32'h0000, 32'h1000, 1'b0);
        wait_valid(10);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("mr_cmd_valid", bus.cmd_valid, 1'b0);
        check("mr_busy", busy, 1'b0);
        check("mr_req_ready", bus.req_ready, 1'b1);
        check("mr_done", done, 1'b0);
        repeat (3) @(negedge clk);
        bus.cmd_ready = 1'b1;
        send_req(32'h0FF0, 32'h40, 1'b0);
        wait_done(50);
        check_test1();

        // address wrap, long INCR from an unaligned page offset, short FIXED tail
        send_req(32'hFFFF_FFF0, 32'h20, 1'b0);
        wait_done(50);
        check_obs(0, 32'hFFFF_FFF0, 8'd3, 2'b01, 1'b0);
        check_obs(1, 32'h0000_0000, 8'd3, 2'b01, 1'b1);
        send_req(32'h0FFC, 32'h2000, 1'b0);
        wait_done(100);
        send_req(32'h3004, 32'h44, 1'b1);
        wait_done(50);

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
